// File: rtl/wb_regfile_pkg.sv
// Shared CPU constants for the ID, EX/MEM, MEM/WB and WB stages.
// Register-file geometry and the data width live here.
package wb_regfile_pkg;

  localparam int REG_AW   = 5;
  localparam int NREGS    = 32;
  localparam int ZERO_REG = 0;
  localparam int DATA_W   = 32;

endpackage

// File: rtl/wb_regfile_core.sv
// Architectural register array: falling-edge write, async clear,
// two combinational read ports with r0 masked to zero.
module regfile_core
  import wb_regfile_pkg::*;
#(
  parameter int NREGS = 1 << REG_AW,
  parameter int DW    = DATA_W,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb
);

  logic [DW-1:0] regs [NREGS];
  logic          wr_ok;

  assign wr_ok = we && (waddr != AW'(ZERO_REG));

  // Commit on the falling edge so decode can read it in the same cycle.
  always_ff @(negedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports; r0 always reads as zero.
  always_comb begin
    qa = (ra == AW'(ZERO_REG)) ? '0 : regs[ra];
    qb = (rb == AW'(ZERO_REG)) ? '0 : regs[rb];
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: result mux, write-through bypass,
// register file and retired-write counter.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int NREGS = 1 << REG_AW,
  parameter int DW    = DATA_W,
  parameter int CNTW  = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            wwreg,
  input  logic            wm2reg,
  input  logic [AW-1:0]   wdestReg,
  input  logic [DW-1:0]   wr,
  input  logic [DW-1:0]   wdo,
  input  logic [AW-1:0]   rs,
  input  logic [AW-1:0]   rt,
  output logic [DW-1:0]   qa,
  output logic [DW-1:0]   qb,
  output logic [DW-1:0]   wbData,
  output logic [CNTW-1:0] wbCount
);

  logic          commit;
  logic [DW-1:0] arr_qa;
  logic [DW-1:0] arr_qb;
  logic [CNTW-1:0] cnt;

  assign commit = wwreg && (wdestReg != AW'(ZERO_REG));

  regfile_core #(
    .NREGS (NREGS),
    .DW    (DW)
  ) u_core (
    .clk   (clk),
    .clrn  (clrn),
    .we    (wwreg),
    .waddr (wdestReg),
    .wdata (wbData),
    .ra    (rs),
    .rb    (rt),
    .qa    (arr_qa),
    .qb    (arr_qb)
  );

  // Result mux plus bypass so decode sees this cycle's write.
  always_comb begin
    wbData = wm2reg ? wdo : wr;
    qa = (commit && (wdestReg == rs)) ? wbData : arr_qa;
    qb = (commit && (wdestReg == rt)) ? wbData : arr_qb;
  end

  // Count committed non-zero writes, same edge as the array.
  always_ff @(negedge clk or negedge clrn) begin
    if (!clrn) cnt <= '0;
    else if (commit) cnt <= cnt + CNTW'(1);
  end

  assign wbCount = cnt;

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file for the five-stage pipelined CPU. Consumes the MEM/WB pipeline register outputs, selects the write-back value (ALU result or loaded data), and commits it to a 32 × 32-bit register file. Serves the two combinational read ports used by instruction decode. Exposes the selected write-back value for the EX-stage forwarding muxes, plus a retired-write counter for debug.

## Interface

**Parameters**
- `NREGS`, default 32: number of architectural registers; must be a power of two.
- `DW`, default 32: data width.
- `CNTW`, default 32: width of the write counter.

**Ports**
- `clk`, input, 1: pipeline clock.
- `clrn`, input, 1: asynchronous active-low reset.
- `wwreg`, input, 1: write-enable from MEM/WB.
- `wm2reg`, input, 1: 1 selects `wdo`, 0 selects `wr`.
- `wdestReg`, input, log2(NREGS): destination register.
- `wr`, input, DW: ALU result from MEM/WB.
- `wdo`, input, DW: memory load data from MEM/WB.
- `rs`, input, log2(NREGS): read address A (decode stage).
- `rt`, input, log2(NREGS): read address B (decode stage).
- `qa`, output, DW: read data A.
- `qb`, output, DW: read data B.
- `wbData`, output, DW: selected write-back value, to forwarding logic.
- `wbCount`, output, CNTW: number of committed writes to nonzero registers.

## Operation

**Write-back mux**
- `wbData = wm2reg ? wdo : wr`.
- Purely combinational; valid whenever MEM/WB is valid, independent of `wwreg`.

**Commit**
- On the falling edge of `clk`, if `clrn`=1, `wwreg`=1 and `wdestReg`≠0: `regs[wdestReg] <= wbData`.
- Register 0 is hardwired to zero.
  - Writes to it are discarded.
  - Such writes do not increment `wbCount`.

**Read**
- `qa = (rs==0) ? 0 : regs[rs]`.
- `qb` is the same function of `rt`.
- Internal write-through bypass, active during the first half of the cycle (before the falling edge):
  - If `wwreg`=1, `wdestReg`≠0 and `wdestReg`==`rs`, then `qa = wbData`.
  - Same rule for `rt`/`qb`.
- With the bypass, decode always sees the value being written in the same cycle.

**Counter**
- `wbCount` increments by 1 on each committed write (falling edge, same condition as commit).
- Wraps modulo 2^CNTW with no saturation or flag.

**Reset**
- `clrn`=0 asynchronously clears all registers and `wbCount` to 0.
- While `clrn`=0:
  - `qa`=`qb`=0, except when the bypass is active (the bypass depends only on inputs).
  - `wbCount`=0.
  - No commits occur.
- Reset asserted mid-cycle, between the rising and falling edges: the pending write is lost and the array remains zero.
- Reset release: the first falling edge with `clrn`=1 may commit.

**Simultaneous events**
- `rs`==`rt`==`wdestReg`: both ports return `wbData`.
- `wdestReg`=0 with `wwreg`=1: no effect on the array, the counter, or the bypass.

## Timing
- Write latency: the value is committed on the falling edge of the cycle in which MEM/WB presents it. It is readable from the array from that edge onward, and via the bypass for the whole cycle.
- Read latency: 0 cycles (combinational from `rs`/`rt`). The decode/execute register captures `qa`/`qb` on the next rising edge.
- A write-back in cycle N followed by a dependent decode read in cycle N therefore needs no stall and no external forwarding.
- `wbData` is combinational from `wm2reg`, `wr` and `wdo`, with zero latency.
- Only the array and `wbCount` are flopped, both on the falling edge. Nothing is clocked on the rising edge.

## Structure
- Shared CPU package holds:
  - `REG_AW` = 5 and `NREGS` = 32.
  - `ZERO_REG` = 0.
  - The data width constant.
  - These are also used by the ID, EX/MEM and MEM/WB stages.
- One sub-module, `regfile_core`, owns:
  - the array;
  - the falling-edge write;
  - the asynchronous clear;
  - the two read ports with zero-register masking.
- The top level holds:
  - the write-back mux;
  - the bypass compare;
  - `wbCount`.

## Test plan
1. Reset, then read all 32 registers → every `qa`/`qb` is 0 and `wbCount`=0.
2. `wwreg`=1, `wm2reg`=0, `wdestReg`=5, `wr`=0x1234_5678, `rs`=5 in the same cycle → `qa`=0x1234_5678 before the falling edge. After the edge `regs[5]`=0x1234_5678 and `wbCount`=1.
3. `wm2reg`=1, `wdo`=0xA000_00AA, `wr`=0xDEAD_BEEF, `wdestReg`=9 → `wbData`=0xA000_00AA and `regs[9]`=0xA000_00AA.
4. `wwreg`=1, `wdestReg`=0, `wr`=0xFFFF_FFFF, `rs`=`rt`=0 → `qa`=`qb`=0, `wbCount` unchanged.
5. Write 0x11 to r3, then hold `wwreg`=0 with `wdestReg`=3 and `wr`=0x22 → `qa`(rs=3) stays 0x11, no bypass, counter unchanged.
6. Write r7 and r8, then pulse `clrn` low mid-cycle while a write to r7 is pending → r7=r8=0, `wbCount`=0, pending write lost. The next write after release commits and sets `wbCount`=1.
